mem_arbiter: RTL



---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 27 ++
 rtl/mem_arbiter_rr_pick.sv | 35 +++
 rtl/mem_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Byte-strobe encodings seen on the requester and memory sides.
  localparam logic [3:0] STRB_READ = 4'b0000;
  localparam logic [3:0] STRB_WORD = 4'b1111;

  // Width of a port index; a single requester still needs one bit.
  function automatic int port_id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the arbiter: per-port request fields plus grant/response.
interface mem_arbiter_if #(
  parameter int N_PORTS = 2
);

  logic [N_PORTS-1:0]    req_i;
  logic [4*N_PORTS-1:0]  wstrb_i;
  logic [32*N_PORTS-1:0] addr_i;
  logic [32*N_PORTS-1:0] wdata_i;
  logic [N_PORTS-1:0]    lock_i;
  logic [N_PORTS-1:0]    gnt_o;
  logic [N_PORTS-1:0]    rvalid_o;
  logic [31:0]           rdata_o;

  // Requesters drive the access fields and observe grant/response.
  modport master (
    output req_i, wstrb_i, addr_i, wdata_i, lock_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  // The arbiter consumes the access fields and drives grant/response.
  modport slave (
    input  req_i, wstrb_i, addr_i, wdata_i, lock_i,
    output gnt_o, rvalid_o, rdata_o
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible request at or after the pointer.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic [N-1:0]     excl_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [N-1:0] cand;

  assign cand = req_i & ~excl_i;

  // Walk the ports starting at the pointer, wrapping, and keep the first hit.
  always_comb begin
    logic [IDX_W-1:0] idx;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDX_W'((int'(ptr_i) + k) % N);
      if (!valid_o && cand[idx]) begin
        valid_o    = 1'b1;
        idx_o      = idx;
        gnt_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory port between N_PORTS requesters with
// round-robin fairness, a bounded lock for RMW sequences and read routing.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_PORTS  = 2,
  parameter int MEM_LAT  = 1,
  parameter int MAX_LOCK = 15
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  mem_arbiter_if.slave bus,
  output logic        mem_enable_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int IDW = port_id_w(N_PORTS);

  arb_state_t         state_q, state_d;
  logic [IDW-1:0]     rrPtr_q, rrPtr_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic [7:0]         lockCnt_q, lockCnt_d;
  logic               pipeValid_q [MEM_LAT];
  logic [IDW-1:0]     pipeId_q    [MEM_LAT];

  logic [N_PORTS-1:0] ownerMask, pickExcl, pickGnt, gntRaw, rvalid;
  logic [IDW-1:0]     pickIdx, gntIdx;
  logic               pickValid, ownerReq, ownerLock, lockMax, readIssue;
  logic [3:0]         wstrbArr [N_PORTS];
  logic [31:0]        addrArr  [N_PORTS];
  logic [31:0]        wdataArr [N_PORTS];

  rr_pick #(
    .N     (N_PORTS),
    .IDX_W (IDW)
  ) u_pick (
    .req_i   (bus.req_i),
    .ptr_i   (rrPtr_q),
    .excl_i  (pickExcl),
    .gnt_o   (pickGnt),
    .idx_o   (pickIdx),
    .valid_o (pickValid)
  );

  // Unpack the flat per-port buses and derive the lock-owner qualifiers.
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      wstrbArr[p] = bus.wstrb_i[p*4 +: 4];
      addrArr[p]  = bus.addr_i[p*32 +: 32];
      wdataArr[p] = bus.wdata_i[p*32 +: 32];
    end
    ownerMask          = '0;
    ownerMask[owner_q] = 1'b1;
    ownerReq           = bus.req_i[owner_q];
    ownerLock          = bus.lock_i[owner_q];
    lockMax            = (lockCnt_q == 8'(MAX_LOCK));
    pickExcl           = '0;
    if (state_q == LOCKED && lockMax && |(bus.req_i & ~ownerMask)) begin
      pickExcl = ownerMask;
    end
  end

  // State register: arbitration state, fairness pointer, lock owner and count.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ARB;
      rrPtr_q   <= '0;
      owner_q   <= '0;
      lockCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rrPtr_q   <= rrPtr_d;
      owner_q   <= owner_d;
      lockCnt_q <= lockCnt_d;
    end
  end

  // Next state: rotate the pointer past each arbitrated winner, enter/leave the lock.
  always_comb begin
    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    owner_d   = owner_q;
    lockCnt_d = lockCnt_q;
    case (state_q)
      ARB: begin
        if (pickValid) begin
          rrPtr_d = IDW'((int'(pickIdx) + 1) % N_PORTS);
          if (bus.lock_i[pickIdx]) begin
            owner_d   = pickIdx;
            lockCnt_d = 8'd1;
            state_d   = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (!ownerReq) begin
          state_d = ARB;
        end else if (lockMax) begin
          state_d = ARB;
          if (pickValid) begin
            rrPtr_d = IDW'((int'(pickIdx) + 1) % N_PORTS);
          end
        end else if (ownerLock) begin
          lockCnt_d = lockCnt_q + 8'd1;
        end else begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Grant and memory mux: same-cycle grant, everything quiet while in reset.
  always_comb begin
    gntRaw = '0;
    gntIdx = '0;
    case (state_q)
      ARB: begin
        gntRaw = pickGnt;
        gntIdx = pickIdx;
      end
      LOCKED: begin
        if (ownerReq) begin
          if (lockMax) begin
            gntRaw = pickGnt;
            gntIdx = pickIdx;
          end else begin
            gntRaw = ownerMask;
            gntIdx = owner_q;
          end
        end
      end
      default: gntRaw = '0;
    endcase
    if (!rstn_i) begin
      gntRaw = '0;
    end
    mem_enable_o = |gntRaw;
    mem_wstrb_o  = STRB_READ;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    if (mem_enable_o) begin
      mem_wstrb_o = wstrbArr[gntIdx];
      mem_addr_o  = addrArr[gntIdx];
      mem_wdata_o = wdataArr[gntIdx];
    end
    readIssue = mem_enable_o && (mem_wstrb_o == STRB_READ);
  end

  // Response pipeline: tag each issued read with its port until data returns.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        pipeValid_q[i] <= 1'b0;
        pipeId_q[i]    <= '0;
      end
    end else begin
      pipeValid_q[0] <= readIssue;
      pipeId_q[0]    <= gntIdx;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipeValid_q[i] <= pipeValid_q[i-1];
        pipeId_q[i]    <= pipeId_q[i-1];
      end
    end
  end

  // Steer the returning read to the port that issued it.
  always_comb begin
    rvalid = '0;
    if (rstn_i && pipeValid_q[MEM_LAT-1]) begin
      rvalid[pipeId_q[MEM_LAT-1]] = 1'b1;
    end
  end

  assign bus.gnt_o    = gntRaw;
  assign bus.rvalid_o = rvalid;
  assign bus.rdata_o  = mem_rdata_i;

endmodule
